car_sequencer: RTL and testbench

CAR_SEQUENCER -- requirements
Module: car_sequencer

---
 rtl/car_sequencer_if.sv | 24 ++
 rtl/car_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_car_sequencer.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/car_sequencer_if.sv
// Bundle for the car sequencer: enable, direction request and call inputs from the controller,
// car status and call-clear pulses back from the sequencer.
interface car_sequencer_if;
  logic        enable;
  logic [1:0]  nextDirection;
  logic [13:0] floorButton;
  logic [7:1]  internalButton;
  logic [2:0]  currentFloor;
  logic [1:0]  currentDirection;
  logic        doorState;
  logic        move;
  logic [13:0] clearFloor;
  logic [7:1]  clearInternal;

  modport master (
    output enable, nextDirection, floorButton, internalButton,
    input  currentFloor, currentDirection, doorState, move, clearFloor, clearInternal
  );

  modport slave (
    input  enable, nextDirection, floorButton, internalButton,
    output currentFloor, currentDirection, doorState, move, clearFloor, clearInternal
  );
endinterface

// File: rtl/car_sequencer.sv
// Single-car elevator sequencer: IDLE / DOOR_OPEN / MOVING with registered outputs.
// Define CAR_SEQUENCER_DOOR_REOPEN_EN to let a current-floor request hold the door open.
module car_sequencer #(
  parameter int unsigned FLOOR_TICKS = 8,
  parameter int unsigned DOOR_TICKS  = 4
) (
  input logic            clk,
  input logic            reset,
  car_sequencer_if.slave bus
);
  localparam logic [1:0] DirStop = 2'b00;
  localparam logic [1:0] DirUp   = 2'b10;
  localparam logic [1:0] DirDown = 2'b01;
  localparam logic [7:0] FloorCnt = 8'(FLOOR_TICKS);
  localparam logic [7:0] DoorCnt  = 8'(DOOR_TICKS);

  typedef enum logic [1:0] {StIdle, StDoorOpen, StMoving} state_e;

  state_e      state_q, state_d;
  logic [2:0]  floor_q, floor_d;
  logic [1:0]  dir_q, dir_d;
  logic        door_q, door_d;
  logic        move_q, move_d;
  logic [7:0]  door_cnt_q, door_cnt_d;
  logic [7:0]  travel_cnt_q, travel_cnt_d;
  logic [13:0] clear_floor_q, clear_floor_d;
  logic [7:1]  clear_int_q, clear_int_d;

  logic [7:1]  req_floor;
  logic [2:0]  nxt_floor;
  logic        going_up, req_here, calls_beyond, stop_here;
  logic        int_nxt, up_nxt, dn_nxt, do_clear;
  int          cur_f, nxt_f, clear_f;

  // Request decode for the current floor and for the floor about to be reached.
  always_comb begin
    going_up     = (dir_q == DirUp);
    nxt_floor    = going_up ? floor_q + 3'd1 : floor_q - 3'd1;
    cur_f        = int'(floor_q);
    nxt_f        = int'(nxt_floor);
    req_floor    = '0;
    req_here     = 1'b0;
    calls_beyond = 1'b0;
    int_nxt      = 1'b0;
    up_nxt       = 1'b0;
    dn_nxt       = 1'b0;
    for (int f = 1; f <= 7; f++) begin
      req_floor[f] = bus.internalButton[f] | bus.floorButton[2*f-1] | bus.floorButton[2*f-2];
      if (f == cur_f) req_here = req_floor[f];
      if (f == nxt_f) begin
        int_nxt = bus.internalButton[f];
        up_nxt  = bus.floorButton[2*f-1];
        dn_nxt  = bus.floorButton[2*f-2];
      end
      if (going_up ? (f > nxt_f) : (f < nxt_f)) calls_beyond = calls_beyond | req_floor[f];
    end
    stop_here = int_nxt | (going_up ? up_nxt : dn_nxt) |
                (going_up ? (nxt_floor == 3'd7) : (nxt_floor == 3'd1)) | ~calls_beyond;
  end

  always_comb begin
    state_d       = state_q;
    floor_d       = floor_q;
    dir_d         = dir_q;
    door_d        = door_q;
    move_d        = move_q;
    door_cnt_d    = door_cnt_q;
    travel_cnt_d  = travel_cnt_q;
    clear_floor_d = '0;
    clear_int_d   = '0;
    do_clear      = 1'b0;
    clear_f       = 0;
    if (bus.enable) begin
      unique case (state_q)
        StIdle: begin
          if (req_here) begin
            state_d    = StDoorOpen;
            door_d     = 1'b1;
            door_cnt_d = DoorCnt;
            do_clear   = 1'b1;
            clear_f    = cur_f;
          end else if (bus.nextDirection == DirUp && floor_q != 3'd7) begin
            state_d      = StMoving;
            move_d       = 1'b1;
            dir_d        = DirUp;
            travel_cnt_d = FloorCnt;
          end else if (bus.nextDirection == DirDown && floor_q != 3'd1) begin
            state_d      = StMoving;
            move_d       = 1'b1;
            dir_d        = DirDown;
            travel_cnt_d = FloorCnt;
          end else if (bus.nextDirection != 2'b11) begin
            dir_d = bus.nextDirection;
          end
        end
        StDoorOpen: begin
`ifdef CAR_SEQUENCER_DOOR_REOPEN_EN
          if (req_here) begin
            door_cnt_d = DoorCnt;
            do_clear   = 1'b1;
            clear_f    = cur_f;
          end else if (door_cnt_q <= 8'd1) begin
            state_d    = StIdle;
            door_d     = 1'b0;
            door_cnt_d = '0;
          end else begin
            door_cnt_d = door_cnt_q - 8'd1;
          end
`else
          if (door_cnt_q <= 8'd1) begin
            state_d    = StIdle;
            door_d     = 1'b0;
            door_cnt_d = '0;
          end else begin
            door_cnt_d = door_cnt_q - 8'd1;
          end
`endif
        end
        StMoving: begin
          if (travel_cnt_q <= 8'd1) begin
            floor_d = nxt_floor;
            if (stop_here) begin
              state_d      = StDoorOpen;
              move_d       = 1'b0;
              door_d       = 1'b1;
              door_cnt_d   = DoorCnt;
              travel_cnt_d = '0;
              do_clear     = 1'b1;
              clear_f      = nxt_f;
            end else begin
              travel_cnt_d = FloorCnt;
            end
          end else begin
            travel_cnt_d = travel_cnt_q - 8'd1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
    if (do_clear) begin
      for (int f = 1; f <= 7; f++) begin
        if (f == clear_f) begin
          clear_int_d[f]       = 1'b1;
          clear_floor_d[2*f-1] = 1'b1;
          clear_floor_d[2*f-2] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      floor_q       <= 3'd1;
      dir_q         <= DirStop;
      door_q        <= 1'b0;
      move_q        <= 1'b0;
      door_cnt_q    <= '0;
      travel_cnt_q  <= '0;
      clear_floor_q <= '0;
      clear_int_q   <= '0;
    end else begin
      state_q       <= state_d;
      floor_q       <= floor_d;
      dir_q         <= dir_d;
      door_q        <= door_d;
      move_q        <= move_d;
      door_cnt_q    <= door_cnt_d;
      travel_cnt_q  <= travel_cnt_d;
      clear_floor_q <= clear_floor_d;
      clear_int_q   <= clear_int_d;
    end
  end

  assign bus.currentFloor     = floor_q;
  assign bus.currentDirection = dir_q;
  assign bus.doorState        = door_q;
  assign bus.move             = move_q;
  assign bus.clearFloor       = clear_floor_q;
  assign bus.clearInternal    = clear_int_q;
endmodule

// File: tb/tb_car_sequencer.sv
// Directed bench for car_sequencer with default FLOOR_TICKS=8, DOOR_TICKS=4.
module tb_car_sequencer;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  car_sequencer_if bus ();

  car_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_floor"}, 32'(bus.currentFloor), 32'd1);
    check_eq({tag, "_dir"}, 32'(bus.currentDirection), 32'd0);
    check_eq({tag, "_door"}, 32'(bus.doorState), 32'd0);
    check_eq({tag, "_move"}, 32'(bus.move), 32'd0);
    check_eq({tag, "_clrf"}, 32'(bus.clearFloor), 32'd0);
    check_eq({tag, "_clri"}, 32'(bus.clearInternal), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b0;
    bus.enable = 1'b1;
    bus.nextDirection = 2'b00;
    bus.floorButton = '0;
    bus.internalButton = '0;
    step(3);
    check_reset_vals("rst");
    reset = 1'b1;

    // Illegal departures at floor 1 are ignored.
    bus.nextDirection = 2'b01;
    step(2);
    check_eq("down_at_1_move", 32'(bus.move), 32'd0);
    bus.nextDirection = 2'b11;
    step(2);
    check_eq("dir11_move", 32'(bus.move), 32'd0);
    check_eq("dir11_door", 32'(bus.doorState), 32'd0);

    // Current-floor call wins over an UP request.
    bus.nextDirection = 2'b10;
    bus.internalButton = 7'h01;
    step(1);
    check_eq("open1_door", 32'(bus.doorState), 32'd1);
    check_eq("open1_move", 32'(bus.move), 32'd0);
    check_eq("open1_clri", 32'(bus.clearInternal), 32'h01);
    check_eq("open1_clrf", 32'(bus.clearFloor), 32'h0003);
    bus.internalButton = '0;
    bus.nextDirection = 2'b00;
    step(1);
    check_eq("open1_clri_off", 32'(bus.clearInternal), 32'h00);
    step(2);
    check_eq("open1_door_e3", 32'(bus.doorState), 32'd1);
    step(1);
    check_eq("open1_door_e4", 32'(bus.doorState), 32'd0);

    // Floor 1 -> 4 in 24 cycles.
    bus.internalButton = 7'h08;
    bus.nextDirection = 2'b10;
    step(1);
    check_eq("up4_move", 32'(bus.move), 32'd1);
    check_eq("up4_dir", 32'(bus.currentDirection), 32'h2);
    check_eq("up4_door", 32'(bus.doorState), 32'd0);
    step(23);
    check_eq("up4_floor_d23", 32'(bus.currentFloor), 32'd3);
    check_eq("up4_move_d23", 32'(bus.move), 32'd1);
    step(1);
    check_eq("up4_floor", 32'(bus.currentFloor), 32'd4);
    check_eq("up4_door_open", 32'(bus.doorState), 32'd1);
    check_eq("up4_move_off", 32'(bus.move), 32'd0);
    check_eq("up4_clri", 32'(bus.clearInternal), 32'h08);
    check_eq("up4_clrf", 32'(bus.clearFloor), 32'h00C0);
    check_eq("up4_dir_held", 32'(bus.currentDirection), 32'h2);
    bus.internalButton = '0;
    bus.nextDirection = 2'b00;
    step(4);
    check_eq("up4_door_close", 32'(bus.doorState), 32'd0);
    step(1);
    check_eq("idle_dir_follow", 32'(bus.currentDirection), 32'h0);

    // Floor 4 -> 2 downward.
    bus.internalButton = 7'h02;
    bus.nextDirection = 2'b01;
    step(1);
    check_eq("dn2_dir", 32'(bus.currentDirection), 32'h1);
    step(8);
    check_eq("dn2_floor3", 32'(bus.currentFloor), 32'd3);
    check_eq("dn2_pass3_move", 32'(bus.move), 32'd1);
    step(8);
    check_eq("dn2_floor2", 32'(bus.currentFloor), 32'd2);
    check_eq("dn2_door", 32'(bus.doorState), 32'd1);
    bus.internalButton = '0;
    bus.nextDirection = 2'b00;
    step(4);

    // Up from 2: opposite-direction hall call at 3 is passed, stop at 5.
    bus.floorButton = 14'h0010;
    bus.internalButton = 7'h10;
    bus.nextDirection = 2'b10;
    step(1);
    check_eq("up5_move", 32'(bus.move), 32'd1);
    step(8);
    check_eq("up5_floor3", 32'(bus.currentFloor), 32'd3);
    check_eq("up5_pass3_door", 32'(bus.doorState), 32'd0);
    check_eq("up5_pass3_clrf", 32'(bus.clearFloor), 32'h0000);
    step(16);
    check_eq("up5_floor5", 32'(bus.currentFloor), 32'd5);
    check_eq("up5_door", 32'(bus.doorState), 32'd1);
    check_eq("up5_clri", 32'(bus.clearInternal), 32'h10);
    check_eq("up5_clrf", 32'(bus.clearFloor), 32'h0300);
    bus.floorButton = '0;
    bus.internalButton = '0;
    bus.nextDirection = 2'b00;
    step(4);

    // Freeze for 10 cycles mid-travel 5 -> 6.
    bus.internalButton = 7'h20;
    bus.nextDirection = 2'b10;
    step(4);
    bus.enable = 1'b0;
    step(10);
    check_eq("frz_floor", 32'(bus.currentFloor), 32'd5);
    check_eq("frz_move", 32'(bus.move), 32'd1);
    bus.enable = 1'b1;
    step(4);
    check_eq("frz_floor_late", 32'(bus.currentFloor), 32'd5);
    step(1);
    check_eq("frz_arrive_floor", 32'(bus.currentFloor), 32'd6);
    check_eq("frz_arrive_door", 32'(bus.doorState), 32'd1);
    bus.internalButton = '0;
    bus.nextDirection = 2'b00;
    step(4);

    // Door re-press at floor 2.
    bus.internalButton = 7'h02;
    bus.nextDirection = 2'b01;
    step(33);
    check_eq("rp_floor", 32'(bus.currentFloor), 32'd2);
    check_eq("rp_door_o0", 32'(bus.doorState), 32'd1);
    bus.internalButton = '0;
    bus.nextDirection = 2'b00;
    step(1);
    bus.internalButton = 7'h02;
    step(1);
`ifdef CAR_SEQUENCER_DOOR_REOPEN_EN
    check_eq("rp_clri_o2", 32'(bus.clearInternal), 32'h02);
    bus.internalButton = '0;
    step(3);
    check_eq("rp_door_o5", 32'(bus.doorState), 32'd1);
    step(1);
    check_eq("rp_door_o6", 32'(bus.doorState), 32'd0);
`else
    check_eq("rp_clri_o2", 32'(bus.clearInternal), 32'h00);
    step(1);
    check_eq("rp_door_o3", 32'(bus.doorState), 32'd1);
    step(1);
    check_eq("rp_door_o4", 32'(bus.doorState), 32'd0);
    step(1);
    check_eq("rp_reopen_door", 32'(bus.doorState), 32'd1);
    check_eq("rp_reopen_clri", 32'(bus.clearInternal), 32'h02);
    bus.internalButton = '0;
    step(3);
    check_eq("rp_door_o8", 32'(bus.doorState), 32'd1);
    step(1);
    check_eq("rp_door_o9", 32'(bus.doorState), 32'd0);
`endif

    // Reset mid-travel just past floor 3.
    bus.internalButton = 7'h10;
    bus.nextDirection = 2'b10;
    step(9);
    check_eq("mr_floor3", 32'(bus.currentFloor), 32'd3);
    step(2);
    reset = 1'b0;
    #1;
    check_reset_vals("mr_async");
    step(2);
    check_reset_vals("mr_hold");
    reset = 1'b1;
    step(1);
    check_eq("mr_resume_move", 32'(bus.move), 32'd1);
    check_eq("mr_resume_dir", 32'(bus.currentDirection), 32'h2);
    check_eq("mr_resume_floor", 32'(bus.currentFloor), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
